mult_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 16x16 partial-product multiplier stage (`mult_p1`) in the Harvard-architecture datapath. It accepts a multiply request from the execute stage and latches the operands. It drives one internal `mult_p1` instance, registers its four partial sums, and reduces them over two adder cycles. It returns the low 16 bits of the product with a one-cycle `done` pulse.

---
 rtl/mult_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - multi-cycle sequencer around the 16x16 partial-product stage mult_p1.
// Accepts a request, registers four partial sums, reduces them in two adder cycles, pulses done.

module mult_p1 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] s0,
   output logic [15:0] s1,
   output logic [15:0] s2,
   output logic [15:0] s3
);

   logic [15:0] r0;
   logic [15:0] r1;
   logic [15:0] r2;
   logic [15:0] r3;

   // One row per multiplier nibble, shifted into place; bits above 15 never reach the result.
   always_comb begin
      r0 = a * {12'h000, b[3:0]};
      r1 = a * {12'h000, b[7:4]};
      r2 = a * {12'h000, b[11:8]};
      r3 = a * {12'h000, b[15:12]};
      s0 = r0;
      s1 = {r1[11:0], 4'h0};
      s2 = {r2[7:0], 8'h00};
      s3 = {r3[3:0], 12'h000};
   end

endmodule

module mult_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [15:0] rs_data,
   input  logic [15:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PP   = 2'd1,
      ST_SUM  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t      state_q,  state_d;
   logic [15:0] op_rs_q,  op_rs_d;
   logic [15:0] op_rd_q,  op_rd_d;
   logic [15:0] p0_q,     p0_d;
   logic [15:0] p1_q,     p1_d;
   logic [15:0] p2_q,     p2_d;
   logic [15:0] p3_q,     p3_d;
   logic [15:0] t0_q,     t0_d;
   logic [15:0] t1_q,     t1_d;
   logic [15:0] result_q, result_d;
   logic        done_q,   done_d;

   logic [15:0] s0;
   logic [15:0] s1;
   logic [15:0] s2;
   logic [15:0] s3;

   // Fed only from the latched operands so port changes mid-operation cannot leak in.
   mult_p1 u_mult_p1 (
      .a  (op_rs_q),
      .b  (op_rd_q),
      .s0 (s0),
      .s1 (s1),
      .s2 (s2),
      .s3 (s3)
   );

   always_comb begin
      state_d  = state_q;
      op_rs_d  = op_rs_q;
      op_rd_d  = op_rd_q;
      p0_d     = p0_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      p3_d     = p3_q;
      t0_d     = t0_q;
      t1_d     = t1_q;
      result_d = result_q;
      done_d   = 1'b0;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_rs_d = rs_data;
                  op_rd_d = rd_data;
                  state_d = ST_PP;
               end
            end
            ST_PP: begin
               p0_d    = s0;
               p1_d    = s1;
               p2_d    = s2;
               p3_d    = s3;
               state_d = ST_SUM;
            end
            ST_SUM: begin
               t0_d    = p0_q + p1_q;
               t1_d    = p2_q + p3_q;
               state_d = ST_FIN;
            end
            ST_FIN: begin
               result_d = t0_q + t1_q;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_rs_q  <= 16'h0000;
         op_rd_q  <= 16'h0000;
         p0_q     <= 16'h0000;
         p1_q     <= 16'h0000;
         p2_q     <= 16'h0000;
         p3_q     <= 16'h0000;
         t0_q     <= 16'h0000;
         t1_q     <= 16'h0000;
         result_q <= 16'h0000;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_rs_q  <= op_rs_d;
         op_rd_q  <= op_rd_d;
         p0_q     <= p0_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         p3_q     <= p3_d;
         t0_q     <= t0_d;
         t1_q     <= t1_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - scoreboard bench for mult_seq_ctrl with directed vectors.

module tb_mult_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [15:0] rs_data;
   logic [15:0] rd_data;
   logic        busy;
   logic        done;
   logic [15:0] result;

   typedef struct {
      logic [15:0] res;
      int          due;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   n_pass;
   int   n_total;

   mult_seq_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .flush   (flush),
      .rs_data (rs_data),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
   endtask

   // Monitor: every done pops the scoreboard; result and arrival cycle are both checked.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {16'h0, result}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
               check({e.name, "_latency"}, cyc, e.due);
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_missing_done"}, 32'h0, 32'h1);
         end
      end
   end

   // Present operands for one accepting edge, then scramble the ports.
   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expv, input string name, input bit track);
      exp_t e;
      @(posedge clk); #1;
      start   = 1'b1;
      rs_data = a;
      rd_data = b;
      if (track) begin
         e.res  = expv;
         e.due  = cyc + 4;
         e.name = name;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start   = 1'b0;
      rs_data = 16'($urandom);
      rd_data = 16'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() > 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("idle_timeout", 32'h1, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      exp_t e;
      cyc     = 0;
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      start   = 1'b0;
      flush   = 1'b0;
      rs_data = 16'h0;
      rd_data = 16'h0;
      #12;
      check("reset_busy",   {31'h0, busy}, 32'h0);
      check("reset_done",   {31'h0, done}, 32'h0);
      check("reset_result", {16'h0, result}, 32'h0);
      rst = 1'b0;

      // Basic, with busy duration counted
      issue(16'd3, 16'd5, 16'h000F, "basic_3x5", 1'b1);
      n = 0;
      while (busy && n < 10) begin
         n++;
         @(posedge clk); #1;
      end
      check("busy_cycles", n, 3);
      wait_idle();

      issue(16'hFFFF, 16'hFFFF, 16'h0001, "wrap_ffff", 1'b1);
      wait_idle();
      issue(16'd300, 16'd300, 16'h5F90, "wrap_300", 1'b1);
      wait_idle();
      issue(16'h1234, 16'h0010, 16'h2340, "wrap_1234", 1'b1);
      wait_idle();

      // Operand isolation: start while busy with new ports is ignored
      issue(16'd7, 16'd9, 16'h003F, "isolate_7x9", 1'b1);
      start   = 1'b1;
      rs_data = 16'd2;
      rd_data = 16'd2;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back with start held through the done cycle
      start   = 1'b1;
      rs_data = 16'h0100;
      rd_data = 16'h0100;
      e.res = 16'h0000; e.due = cyc + 4; e.name = "b2b_first";  exp_q.push_back(e);
      e.res = 16'h01FE; e.due = cyc + 8; e.name = "b2b_second"; exp_q.push_back(e);
      @(posedge clk); #1;
      rs_data = 16'h00FF;
      rd_data = 16'h0002;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // Flush in SUM
      issue(16'd3, 16'd3, 16'h0, "flush_op", 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy",   {31'h0, busy}, 32'h0);
      check("flush_done",   {31'h0, done}, 32'h0);
      check("flush_result", {16'h0, result}, 32'h01FE);
      repeat (5) @(posedge clk);
      #1;
      check("flush_result_hold", {16'h0, result}, 32'h01FE);

      // Flush with start in IDLE
      start = 1'b1;
      flush = 1'b1;
      rs_data = 16'd6;
      rd_data = 16'd6;
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_busy", {31'h0, busy}, 32'h0);
      repeat (5) @(posedge clk);
      #1;

      // Asynchronous reset while in PP
      issue(16'd5, 16'd5, 16'h0, "rst_op", 1'b0);
      check("pp_busy", {31'h0, busy}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy",   {31'h0, busy}, 32'h0);
      check("async_rst_done",   {31'h0, done}, 32'h0);
      check("async_rst_result", {16'h0, result}, 32'h0);
      #3;
      rst = 1'b0;
      issue(16'd4, 16'd4, 16'h0010, "post_rst_4x4", 1'b1);
      wait_idle();
      repeat (6) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
